// File: rtl/calc1_port_responder.sv
// calc1_port_responder: single-port calc1 execution engine; CALC1_DROP_CNT_EN adds a saturating dropped-command counter
module calc1_port_responder #(
    parameter int EXEC_CYCLES = 3,
    parameter int SHIFT_BITS  = 5
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [0:3]  req_cmd_in,
    input  logic [0:31] req_data_in,
    output logic [0:1]  out_resp,
    output logic [0:31] out_data,
    output logic        busy
`ifdef CALC1_DROP_CNT_EN
    ,
    output logic [0:7]  drop_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, OP2, EXEC, RESP} state_t;
    state_t state;
    logic [0:3] cmd;
    logic [0:3] cnt;
    logic [0:31] op1;
    logic [0:31] op2;
    logic [0:32] sum;
    logic [0:SHIFT_BITS-1] amt;
    logic [0:1] res_resp;
    logic [0:31] res_data;
    assign busy = state != IDLE;
    always_comb begin
        sum = {1'b0, op1} + {1'b0, op2};
        amt = op2[32-SHIFT_BITS:31];
        res_resp = 2'd2;
        res_data = '0;
        case (cmd)
            4'd1: if (!sum[0]) {res_resp, res_data} = {2'd1, sum[1:32]};
            4'd2: if (op1 >= op2) {res_resp, res_data} = {2'd1, op1 - op2};
            4'd5: {res_resp, res_data} = {2'd1, op1 << amt};
            4'd6: {res_resp, res_data} = {2'd1, op1 >> amt};
            default: ;
        endcase
    end
    always_ff @(posedge c_clk) begin
        if (!reset) begin
            state <= IDLE;
            cmd <= '0;
            cnt <= '0;
            op1 <= '0;
            op2 <= '0;
            out_resp <= '0;
            out_data <= '0;
        end else begin
            out_resp <= '0;
            out_data <= '0;
            case (state)
                IDLE: if (req_cmd_in != 4'd0) begin
                    cmd <= req_cmd_in;
                    op1 <= req_data_in;
                    state <= OP2;
                end
                OP2: begin
                    op2 <= req_data_in;
                    cnt <= 4'(EXEC_CYCLES - 1);
                    state <= EXEC;
                end
                EXEC: if (cnt == 4'd0) begin
                    out_resp <= res_resp;
                    out_data <= res_data;
                    state <= RESP;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef CALC1_DROP_CNT_EN
    always_ff @(posedge c_clk) begin
        if (!reset)
            drop_cnt <= '0;
        else if (busy && state != OP2 && req_cmd_in != 4'd0 && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end
`endif
endmodule

// File: tb/tb_calc1_port_responder.sv
// tb_calc1_port_responder: randomized self-checking bench against a behavioural calc1 model
module tb_calc1_port_responder;
    localparam int SB = 5;
    logic c_clk = 1'b0;
    logic reset = 1'b0;
    logic [0:3] req_cmd_in = '0;
    logic [0:31] req_data_in = '0;
    logic [0:1] out_resp;
    logic [0:31] out_data;
    logic busy;
`ifdef CALC1_DROP_CNT_EN
    logic [0:7] drop_cnt;
`endif
    int total = 0;
    int bad = 0;
    int exp_drop = 0;

    always #5 c_clk = ~c_clk;

    calc1_port_responder dut (
        .c_clk(c_clk),
        .reset(reset),
        .req_cmd_in(req_cmd_in),
        .req_data_in(req_data_in),
        .out_resp(out_resp),
        .out_data(out_data),
        .busy(busy)
`ifdef CALC1_DROP_CNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [1:0] r, output logic [31:0] d);
        longint s;
        int amt;
        r = 2'd2;
        d = 32'd0;
        amt = int'(b) & ((1 << SB) - 1);
        case (c)
            4'd1: begin
                s = longint'(a) + longint'(b);
                if (s < 64'h1_0000_0000) begin r = 2'd1; d = s[31:0]; end
            end
            4'd2: if (a >= b) begin r = 2'd1; d = a - b; end
            4'd5: begin r = 2'd1; d = a << amt; end
            4'd6: begin r = 2'd1; d = a >> amt; end
            default: ;
        endcase
    endfunction

    // Caller is at a negedge with the DUT idle; returns at the negedge of the idle cycle after RESP.
    task automatic txn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input int ndrop, input string nm);
        logic [1:0] er, xr;
        logic [31:0] ed, xd;
        logic xb;
        model(c, a, b, er, ed);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s start_busy got=%b want=0", nm, busy);
        end
        req_cmd_in = c;
        req_data_in = a;
        for (int k = 1; k <= 6; k++) begin
            @(negedge c_clk);
            xr = (k == 5) ? er : 2'd0;
            xd = (k == 5) ? ed : 32'd0;
            xb = k <= 5;
            total++;
            if (out_resp !== xr || out_data !== xd || busy !== xb) begin
                bad++;
                $display("FAIL %s cyc%0d got resp=%0d data=%h busy=%b want resp=%0d data=%h busy=%b",
                         nm, k, out_resp, out_data, busy, xr, xd, xb);
            end
            if (k >= 2 && k <= 5 && k - 1 <= ndrop) begin
                req_cmd_in = 4'($urandom_range(1, 15));
                if (exp_drop < 255) exp_drop++;
            end else begin
                req_cmd_in = (k == 1) ? 4'($urandom) : 4'd0;
            end
            req_data_in = (k == 1) ? b : $urandom;
        end
        req_cmd_in = 4'd0;
`ifdef CALC1_DROP_CNT_EN
        total++;
        if (drop_cnt !== 8'(exp_drop)) begin
            bad++;
            $display("FAIL %s drop_cnt got=%0d want=%0d", nm, drop_cnt, exp_drop);
        end
`endif
    endtask

    task automatic test_reset;
        reset = 1'b0;
        exp_drop = 0;
        repeat (4) @(negedge c_clk);
        total++;
        if (out_resp !== 2'd0 || out_data !== 32'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset got resp=%0d data=%h busy=%b want 0/0/0", out_resp, out_data, busy);
        end
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge c_clk);
            total++;
            if (out_resp !== 2'd0 || out_data !== 32'd0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL noop_idle got resp=%0d data=%h busy=%b want 0/0/0", out_resp, out_data, busy);
            end
        end
    endtask

    task automatic test_add;
        txn(4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 0, "add_basic");
        txn(4'd1, 32'h8000_0000, 32'h7FFF_FFFF, 0, "add_max");
    endtask

    task automatic test_overflow;
        txn(4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 0, "add_ovf");
        txn(4'd2, 32'd1, 32'hF, 0, "sub_unf");
        txn(4'd2, 32'd5, 32'd5, 0, "sub_eq");
    endtask

    task automatic test_shift;
        txn(4'd5, 32'h0000_0001, 32'hFFFF_FFFF, 0, "shl31");
        txn(4'd6, 32'h8000_0000, 32'h0000_0020, 0, "shr0");
        txn(4'd6, 32'hF000_000F, 32'h0000_0004, 0, "shr4");
    endtask

    task automatic test_back_to_back;
        txn(4'd3, 32'h1234_5678, 32'h9ABC_DEF0, 0, "inv3");
        txn(4'd4, 32'h0000_0001, 32'h0000_0002, 0, "inv4");
    endtask

    task automatic test_drop;
        txn(4'd1, 32'd10, 32'd20, 1, "drop_one");
        for (int i = 0; i < 75; i++)
            txn(4'($urandom_range(1, 15)), $urandom, $urandom, 4, "drop_sat");
`ifdef CALC1_DROP_CNT_EN
        total++;
        if (drop_cnt !== 8'd255) begin
            bad++;
            $display("FAIL drop_saturate got=%0d want=255", drop_cnt);
        end
`endif
    endtask

    task automatic test_mid_reset;
        req_cmd_in = 4'd1;
        req_data_in = 32'd7;
        @(negedge c_clk);
        req_cmd_in = 4'd0;
        req_data_in = 32'd9;
        @(negedge c_clk);
        reset = 1'b0;
        exp_drop = 0;
        @(negedge c_clk);
        total++;
        if (out_resp !== 2'd0 || out_data !== 32'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset got resp=%0d data=%h busy=%b want 0/0/0", out_resp, out_data, busy);
        end
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge c_clk);
            total++;
            if (out_resp !== 2'd0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL midreset_quiet cyc%0d got resp=%0d busy=%b want 0/0", k, out_resp, busy);
            end
        end
        txn(4'd1, 32'd2, 32'd3, 0, "fresh_add");
    endtask

    task automatic test_random;
        logic [31:0] ops [2];
        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < 2; j++) begin
                case ($urandom_range(0, 3))
                    0: ops[j] = 32'd0;
                    1: ops[j] = 32'hFFFF_FFFF;
                    2: ops[j] = $urandom_range(0, 40);
                    default: ops[j] = $urandom;
                endcase
            end
            txn(4'($urandom_range(1, 15)), ops[0], ops[1], $urandom_range(0, 4), "random");
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_overflow;
        test_shift;
        test_back_to_back;
        test_drop;
        test_mid_reset;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/calc1_port_responder.md
Name: calc1_port_responder

Overview:
- Single-port responder for the calc1 request/response protocol: accepts a command and two operands from one requester port and returns exactly one response word and one response code.
- Serves as the reusable per-port execution engine behind the calc1 request interface, and as a bench-side reference responder.
- Uses the codebase big-endian vectors: bit 0 is the MSB.

Parameters:
- EXEC_CYCLES, 3, number of execute cycles between operand-2 capture and the response cycle; legal range 1..15.
- SHIFT_BITS, 5, operand-2 LSBs used as the shift amount.

Ports:
- c_clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset; synchronous, active-low (0 = reset).
- req_cmd_in  input  [0:3]  command: 0 no-op, 1 add, 2 subtract, 5 shift left, 6 shift right; all other values are invalid.
- req_data_in  input  [0:31]  operand 1 in the command cycle, operand 2 in the following cycle.
- out_resp  output  [0:1]  0 none, 1 success, 2 overflow/underflow/invalid command, 3 never driven.
- out_data  output  [0:31]  result; valid only when out_resp=1.
- busy  output  1  high from the cycle after command capture through the response cycle.

Behaviour:
- Reset (reset=0 at an edge): state IDLE; out_resp=0, out_data=0, busy=0; all internal registers cleared. Reset has priority over every other event, including mid-operation; an in-flight command is discarded and produces no response.
- IDLE:
  - req_cmd_in=0: remain in IDLE.
  - req_cmd_in≠0: latch cmd and op1 = req_data_in, go to OP2.
- OP2: latch op2 = req_data_in unconditionally; req_cmd_in is ignored. Load exec counter with EXEC_CYCLES-1, go to EXEC.
- EXEC:
  - Compute the result combinationally from the latched registers.
  - Decrement the counter; when it reads 0, go to RESP.
  - Register out_resp and out_data so they appear during the RESP cycle.
- RESP: out_resp and out_data are held for exactly one cycle, then the block returns to IDLE.
  - The earliest next command is sampled in the cycle after RESP.
  - Command-to-response latency is therefore EXEC_CYCLES+2 edges after command capture; the default is 5.
- busy is 1 in OP2, EXEC and RESP, and 0 in IDLE.
- Commands presented while busy=1 (excluding the OP2 operand cycle) are silently dropped.
- out_resp=0 and out_data=0 in every non-RESP cycle.
- Arithmetic:
  - add: 33-bit sum. Carry-out=1 gives resp 2, data 0; otherwise resp 1, data = sum.
  - subtract: op1<op2 (unsigned) gives resp 2, data 0; otherwise resp 1, data = op1-op2. Equal operands give resp 1, data 0.
  - shift left/right: logical shift by op2[32-SHIFT_BITS:31], zero-fill, always resp 1. A shift amount of 0 returns op1 unchanged. Upper op2 bits are ignored.
  - invalid cmd (3,4,7..15): follows the same latency, then resp 2, data 0.
- Exactly one response per accepted command; no response for no-ops or dropped commands.

Optional Feature:
- Macro CALC1_DROP_CNT_EN.
- When defined:
  - Adds output drop_cnt [0:7], reset to 0.
  - Increments by 1 for each cycle in which busy=1, state≠OP2 and req_cmd_in≠0.
  - Saturates at 255; does not wrap.
- When undefined: no port and no counter logic. Drop behaviour is otherwise identical.

Test Plan:
- Reset low 4 cycles, then high: out_resp=0, out_data=0, busy=0. Then cmd 1, op1 0x0000_0001, op2 0x1FFF_FFFF: resp 1, data 0x2000_0000 exactly 5 edges after capture, for one cycle only.
- Overflow and underflow:
  - cmd 1, op1 0xFFFF_FFFF, op2 0x0000_0001: resp 2, data 0.
  - cmd 2, op1 1, op2 0xF: resp 2, data 0.
  - cmd 2, op1 5, op2 5: resp 1, data 0.
- Shifts:
  - cmd 5, op1 0x0000_0001, op2 0xFFFF_FFFF (amount 31): resp 1, data 0x8000_0000.
  - cmd 6, op1 0x8000_0000, op2 0x20 (amount 0): resp 1, data 0x8000_0000.
- Invalid commands 3 then 4, back-to-back at earliest legal acceptance: two responses of resp 2 at the same 5-edge latency, with no overlap and exactly one idle cycle between them.
- Command drop: cmd 1 issued while busy during EXEC yields no extra response. With CALC1_DROP_CNT_EN defined, drop_cnt increments from 0 to 1; 300 drops saturate drop_cnt at 255.
- Reset mid-operation: reset=0 during EXEC yields no response; outputs are 0 on the next edge; a fresh add (2+3) afterwards gives resp 1, data 5.
